// File: rtl/fifo_key_frontend.sv
// Push-button / switch front end for the 4-bit FIFO.
// Debounces keys, captures data and issues guarded strobes.

module fifo_key_frontend_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

   // state and stability counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RELEASED;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // a level must hold for DEBOUNCE_CYCLES samples to be accepted
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press     = 1'b0;
      unique case (state)
         RELEASED: begin
            if (!key_n) begin
               cnt_nxt   = '0;
               state_nxt = PRESS_WAIT;
            end
         end
         PRESS_WAIT: begin
            if (key_n) begin
               state_nxt = RELEASED;
            end else if (cnt == LAST) begin
               state_nxt = PRESSED;
               press     = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_WIDTH'(1);
            end
         end
         PRESSED: begin
            if (key_n) begin
               cnt_nxt   = '0;
               state_nxt = RELEASE_WAIT;
            end
         end
         RELEASE_WAIT: begin
            if (!key_n) begin
               state_nxt = PRESSED;
            end else if (cnt == LAST) begin
               state_nxt = RELEASED;
            end else begin
               cnt_nxt = cnt + CNT_WIDTH'(1);
            end
         end
         default: state_nxt = RELEASED;
      endcase
   end

endmodule

module fifo_key_frontend #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20,
   parameter int PULSE_CYCLES    = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             key_write_n,
   input  logic             key_read_n,
   input  logic [WIDTH-1:0] sw_data,
   input  logic             fifo_full,
   input  logic             fifo_empty,
   output logic             wr_en,
   output logic             rd_en,
   output logic [WIDTH-1:0] wr_data,
   output logic             overflow_flag,
   output logic             underflow_flag
);

   localparam int PW = $clog2(PULSE_CYCLES + 1);

   logic [1:0]       wk_sync;
   logic [1:0]       rk_sync;
   logic [WIDTH-1:0] sw_s1;
   logic [WIDTH-1:0] sw_s2;
   logic             w_ev;
   logic             r_ev;
   logic [PW-1:0]    wr_cnt;
   logic [PW-1:0]    rd_cnt;
   logic             wr_busy;
   logic             rd_busy;
   logic             wr_acc;
   logic             wr_blk;
   logic             rd_acc;
   logic             rd_blk;

   // two-flop synchronizers, idle level is released
   always_ff @(posedge clock) begin
      if (reset) begin
         wk_sync <= 2'b11;
         rk_sync <= 2'b11;
         sw_s1   <= '1;
         sw_s2   <= '1;
      end else begin
         wk_sync <= {wk_sync[0], key_write_n};
         rk_sync <= {rk_sync[0], key_read_n};
         sw_s1   <= sw_data;
         sw_s2   <= sw_s1;
      end
   end

   fifo_key_frontend_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_db_write (
      .clock(clock),
      .reset(reset),
      .key_n(wk_sync[1]),
      .press(w_ev)
   );

   fifo_key_frontend_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_db_read (
      .clock(clock),
      .reset(reset),
      .key_n(rk_sync[1]),
      .press(r_ev)
   );

   assign wr_busy = (wr_cnt != '0);
   assign rd_busy = (rd_cnt != '0);

   // events during an active strobe are dropped silently;
   // a read on empty is fine when a write lands alongside it
   assign wr_acc = w_ev & ~wr_busy & ~fifo_full;
   assign wr_blk = w_ev & ~wr_busy & fifo_full;
   assign rd_acc = r_ev & ~rd_busy & (~fifo_empty | wr_acc);
   assign rd_blk = r_ev & ~rd_busy & fifo_empty & ~wr_acc;

   // strobe counters, data capture and sticky error flags
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_cnt         <= '0;
         rd_cnt         <= '0;
         wr_data        <= '0;
         overflow_flag  <= 1'b0;
         underflow_flag <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_cnt  <= PW'(PULSE_CYCLES);
            wr_data <= sw_s2;
         end else if (wr_busy) begin
            wr_cnt <= wr_cnt - PW'(1);
         end
         if (rd_acc) begin
            rd_cnt <= PW'(PULSE_CYCLES);
         end else if (rd_busy) begin
            rd_cnt <= rd_cnt - PW'(1);
         end
         if (wr_blk) overflow_flag <= 1'b1;
         if (rd_blk) underflow_flag <= 1'b1;
      end
   end

   assign wr_en = wr_busy;
   assign rd_en = rd_busy;

endmodule

// File: tb/tb_fifo_key_frontend.sv
// Scoreboard bench for fifo_key_frontend.
// Two instances: 1-cycle strobes and 3-cycle strobes.

module tb_fifo_key_frontend;

   logic       clock = 1'b0;
   logic       reset;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   logic       kw1, kr1, full1, empty1;
   logic [3:0] sw1;
   logic       wr_en1, rd_en1, ovf1, unf1;
   logic [3:0] wr_data1;

   logic       kw3, kr3, full3, empty3;
   logic [3:0] sw3;
   logic       wr_en3, rd_en3, ovf3, unf3;
   logic [3:0] wr_data3;

   typedef struct {
      int       cyc;
      bit       wr;
      bit       rd;
      logic [3:0] data;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   fifo_key_frontend #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH(20), .PULSE_CYCLES(1)
   ) dut (
      .clock(clock), .reset(reset),
      .key_write_n(kw1), .key_read_n(kr1),
      .sw_data(sw1), .fifo_full(full1),
      .fifo_empty(empty1), .wr_en(wr_en1),
      .rd_en(rd_en1), .wr_data(wr_data1),
      .overflow_flag(ovf1), .underflow_flag(unf1)
   );

   fifo_key_frontend #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH(20), .PULSE_CYCLES(3)
   ) dut3 (
      .clock(clock), .reset(reset),
      .key_write_n(kw3), .key_read_n(kr3),
      .sw_data(sw3), .fifo_full(full3),
      .fifo_empty(empty3), .wr_en(wr_en3),
      .rd_en(rd_en3), .wr_data(wr_data3),
      .overflow_flag(ovf3), .underflow_flag(unf3)
   );

   task automatic expect_pulse(input int inst, input int start,
                               input int width, input bit wr,
                               input bit rd, input logic [3:0] d);
      exp_t e;
      for (int i = 0; i < width; i++) begin
         e.cyc  = start + i;
         e.wr   = wr;
         e.rd   = rd;
         e.data = d;
         if (inst == 1) q1.push_back(e);
         else q3.push_back(e);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // monitor for the 1-cycle instance
   always @(negedge clock) begin
      exp_t e;
      if (wr_en1 === 1'b1 || rd_en1 === 1'b1) begin
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL strobe1 unexpected: cyc=%0d wr=%b rd=%b",
                     cyc, wr_en1, rd_en1);
         end else begin
            e = q1.pop_front();
            if (e.cyc != cyc || e.wr !== wr_en1 || e.rd !== rd_en1 ||
                (e.wr && wr_data1 !== e.data)) begin
               n_fail++;
               $display("FAIL strobe1: got cyc=%0d wr=%b rd=%b d=%h, expected cyc=%0d wr=%b rd=%b d=%h",
                        cyc, wr_en1, rd_en1, wr_data1,
                        e.cyc, e.wr, e.rd, e.data);
            end
         end
      end
   end

   // monitor for the 3-cycle instance
   always @(negedge clock) begin
      exp_t e;
      if (wr_en3 === 1'b1 || rd_en3 === 1'b1) begin
         n_tests++;
         if (q3.size() == 0) begin
            n_fail++;
            $display("FAIL strobe3 unexpected: cyc=%0d wr=%b rd=%b",
                     cyc, wr_en3, rd_en3);
         end else begin
            e = q3.pop_front();
            if (e.cyc != cyc || e.wr !== wr_en3 || e.rd !== rd_en3 ||
                (e.wr && wr_data3 !== e.data)) begin
               n_fail++;
               $display("FAIL strobe3: got cyc=%0d wr=%b rd=%b d=%h, expected cyc=%0d wr=%b rd=%b d=%h",
                        cyc, wr_en3, rd_en3, wr_data3,
                        e.cyc, e.wr, e.rd, e.data);
            end
         end
      end
   end

   initial begin
      int t;
      reset = 1'b1;
      kw1 = 1'b1; kr1 = 1'b1; sw1 = 4'h0;
      full1 = 1'b0; empty1 = 1'b0;
      kw3 = 1'b1; kr3 = 1'b1; sw3 = 4'h0;
      full3 = 1'b0; empty3 = 1'b0;

      // reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_wr_en", {31'b0, wr_en1}, 0);
      check("rst_rd_en", {31'b0, rd_en1}, 0);
      check("rst_wr_data", {28'b0, wr_data1}, 0);
      check("rst_ovf", {31'b0, ovf1}, 0);
      check("rst_unf", {31'b0, unf1}, 0);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // clean write
      sw1 = 4'hA; kw1 = 1'b0; t = cyc;
      expect_pulse(1, t + 7, 1, 1, 0, 4'hA);
      repeat (20) @(negedge clock);
      check("write_data_hold", {28'b0, wr_data1}, 32'hA);
      kw1 = 1'b1;
      repeat (12) @(negedge clock);

      // bounce rejection on read
      kr1 = 1'b0; repeat (2) @(negedge clock);
      kr1 = 1'b1; repeat (1) @(negedge clock);
      kr1 = 1'b0; repeat (3) @(negedge clock);
      kr1 = 1'b1; repeat (1) @(negedge clock);
      kr1 = 1'b0; t = cyc;
      expect_pulse(1, t + 7, 1, 0, 1, 4'h0);
      repeat (20) @(negedge clock);
      kr1 = 1'b1;
      repeat (12) @(negedge clock);

      // long hold, then re-press
      sw1 = 4'hC; kw1 = 1'b0; t = cyc;
      expect_pulse(1, t + 7, 1, 1, 0, 4'hC);
      repeat (100) @(negedge clock);
      kw1 = 1'b1;
      repeat (10) @(negedge clock);
      sw1 = 4'h3; kw1 = 1'b0; t = cyc;
      expect_pulse(1, t + 7, 1, 1, 0, 4'h3);
      repeat (20) @(negedge clock);
      check("repress_data", {28'b0, wr_data1}, 32'h3);
      kw1 = 1'b1;
      repeat (12) @(negedge clock);

      // blocked write and read
      full1 = 1'b1; sw1 = 4'h9; kw1 = 1'b0;
      repeat (20) @(negedge clock);
      check("ovf_set", {31'b0, ovf1}, 1);
      check("ovf_no_unf", {31'b0, unf1}, 0);
      check("ovf_data_kept", {28'b0, wr_data1}, 32'h3);
      kw1 = 1'b1;
      repeat (50) @(negedge clock);
      check("ovf_sticky", {31'b0, ovf1}, 1);
      full1 = 1'b0;
      empty1 = 1'b1; kr1 = 1'b0;
      repeat (20) @(negedge clock);
      check("unf_set", {31'b0, unf1}, 1);
      kr1 = 1'b1;
      repeat (12) @(negedge clock);
      empty1 = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst_clr_ovf", {31'b0, ovf1}, 0);
      check("rst_clr_unf", {31'b0, unf1}, 0);
      check("rst_clr_data", {28'b0, wr_data1}, 0);
      repeat (3) @(negedge clock);

      // simultaneous press into an empty FIFO, 3-cycle strobes
      empty3 = 1'b1; sw3 = 4'h5;
      kw3 = 1'b0; kr3 = 1'b0; t = cyc;
      expect_pulse(3, t + 7, 3, 1, 1, 4'h5);
      repeat (20) @(negedge clock);
      check("pass_unf", {31'b0, unf3}, 0);
      check("pass_data", {28'b0, wr_data3}, 32'h5);
      kw3 = 1'b1; kr3 = 1'b1;
      repeat (12) @(negedge clock);

      // reset mid-pulse, keys still held afterwards
      kw3 = 1'b0; kr3 = 1'b0; t = cyc;
      expect_pulse(3, t + 7, 1, 1, 1, 4'h5);
      repeat (7) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_wr_en", {31'b0, wr_en3}, 0);
      check("abort_rd_en", {31'b0, rd_en3}, 0);
      t = cyc;
      expect_pulse(3, t + 7, 3, 1, 1, 4'h5);
      repeat (20) @(negedge clock);
      check("repress_unf", {31'b0, unf3}, 0);
      kw3 = 1'b1; kr3 = 1'b1;
      repeat (20) @(negedge clock);

      check("q1_drained", q1.size(), 0);
      check("q3_drained", q3.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
